line_clear_sequencer: RTL
=========================

# line_clear_sequencer

Sequences the full-row clear for the 10x20 playfield between game logic and the VGA display datapath. On a `start` pulse it snapshots the object matrix, detects full rows, drives the display's per-cell `flash` mask so those rows blink for a frame-counted interval, then compacts the matrix and issues a single write-back. It owns the `flash[199:0]` input of the display path, which is tied off today. Pacing comes from a per-frame tick derived from `vs`.

## Interface
- `FLASH_FRAMES`, default 8: frames per blink phase (on or off), ≥1.
- `FLASH_PHASES`, default 6: number of blink phases, even and ≥2, so the sequence ends with the flash off.
- `clk` input 1: 25 MHz pixel clock, shared with the display.
- `clrn` input 1: reset; asynchronous, active-low.
- `start` input 1: one-cycle request after a piece locks.
- `frame_tick` input 1: one-cycle pulse per frame (vs edge), synchronous to `clk`.
- `matrix_in` input 200: playfield; bit `row*10+col`, row 0 at the top, row 19 at the bottom.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `flash` output 200: per-cell flash enable for the display.
- `matrix_out` output 200: compacted playfield, valid when `matrix_we`=1.
- `matrix_we` output 1: one-cycle write strobe for `matrix_out`.
- `lines_cleared` output 5: number of full rows removed (0–20), valid with `done`.
- `done` output 1: one-cycle completion pulse.

## Operation
- States: IDLE, SCAN, FLASH, COMPACT, WRITE, DONE.
- **IDLE**
  - On `start`=1: latch `matrix_in` into `snap`, go to SCAN.
  - `start` is ignored in every state other than IDLE.
- **SCAN** (1 cycle)
  - `full[r]` = AND of the 10 bits of row r; `lines_cleared` = popcount(`full`).
  - If `full`==0: go to DONE.
  - Otherwise: phase=0, frame counter=0, go to FLASH.
- **FLASH**
  - `flash` bit `r*10+c` = `full[r]` when the phase index is even; all zeros when it is odd.
  - Each `frame_tick` increments the frame counter.
  - When the counter reaches `FLASH_FRAMES-1` and a tick arrives: counter←0, phase++.
  - After phase `FLASH_PHASES-1` completes: go to COMPACT.
  - `flash` is 0 in every state except FLASH.
- **COMPACT** (exactly 20 cycles)
  - Read pointer rd runs from 19 down to 0; write pointer wr starts at 19.
  - Each cycle: if `full[rd]`=0, copy `snap` row rd to `out` row wr and decrement wr; otherwise skip the row.
  - On the last cycle, rows 0..wr that were not written are zero.
  - The `out` register is cleared on entry to COMPACT.
- **WRITE** (1 cycle)
  - `matrix_out`=`out`, `matrix_we`=1, `done`=1.
  - Then go to IDLE.
- **DONE** (1 cycle, no-clear path only)
  - `done`=1, `matrix_we`=0, `lines_cleared`=0.
  - Then go to IDLE.
- Row ordering within each row is preserved (bit c stays at column c).

## Timing
- Reset (`clrn`=0, any time): state IDLE.
  - `busy`, `flash`, `matrix_we`, `done` = 0.
  - `matrix_out`, `lines_cleared` = 0.
  - Counters and `snap` cleared; no write is issued.
- `start` is sampled at edge k. SCAN occupies cycle k+1, and `busy`=1 from k+1.
- No-clear path: `done` at k+2. `busy` falls at k+3.
- Clear path:
  - FLASH is entered at k+2.
  - A `frame_tick` coincident with the FLASH entry edge is not counted; counting starts the cycle after entry.
  - FLASH lasts until the `FLASH_FRAMES*FLASH_PHASES`-th counted tick (48 with defaults).
  - COMPACT takes 20 cycles, then WRITE takes 1.
- `matrix_we` and `done` are never high for more than one cycle.
- `matrix_in` changes after k have no effect.
- `lines_cleared` holds its value until the next SCAN.

## Test plan
- **No full rows.** `matrix_in` has only bit 195 set, pulse `start` → `done` 2 cycles later, `lines_cleared`=0, `matrix_we` never asserts, `flash` stays 0.
- **Single bottom row.** Row 19 full (bits 190–199) plus bit 185 → `flash` = bits 190–199 during even phases; after 48 ticks and 21 cycles, `matrix_we`=1, `matrix_out` has only bit 195 set, `lines_cleared`=1.
- **Two split rows.** Rows 17 and 19 full, plus bits 180 and 169 → `matrix_out` has bits 190 and 189 only, `lines_cleared`=2.
- **All rows full.** `matrix_in` all ones → `matrix_out`=0, `lines_cleared`=20, `flash` all ones in phase 0.
- **Start while busy.** Extra `start` pulses during FLASH and COMPACT → ignored; exactly one `done` and one `matrix_we`.
- **Reset mid-flash.** `clrn` low during phase 3 → `flash`=0 and `busy`=0 immediately, no `matrix_we`; after release, a new `start` runs a full sequence with correct output.

Source files
------------

// File: rtl/line_clear_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : line_clear_sequencer
// Brief    : Detects full playfield rows, blinks them via the per-cell flash
//            mask for a frame-counted interval, then compacts and writes back.
// Revision : 1.0 - initial release
// ============================================================================
module line_clear_sequencer #(
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_PHASES = 6
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         i_start,
    input  logic         i_frame_tick,
    input  logic [199:0] i_matrix_in,
    output logic         o_busy,
    output logic [199:0] o_flash,
    output logic [199:0] o_matrix_out,
    output logic         o_matrix_we,
    output logic [4:0]   o_lines_cleared,
    output logic         o_done
);

    localparam int c_ROWS = 20;
    localparam int c_COLS = 10;
    localparam int c_FR_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int c_PH_W = (FLASH_PHASES > 1) ? $clog2(FLASH_PHASES) : 1;
    localparam logic [c_FR_W-1:0] c_LAST_FRAME = c_FR_W'(FLASH_FRAMES - 1);
    localparam logic [c_PH_W-1:0] c_LAST_PHASE = c_PH_W'(FLASH_PHASES - 1);
    localparam logic [4:0]        c_BOTTOM_ROW = 5'(c_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCAN    = 3'd1,
        S_FLASH   = 3'd2,
        S_COMPACT = 3'd3,
        S_WRITE   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              r_state;
    logic [199:0]        r_snap;
    logic [199:0]        r_out;
    logic [c_ROWS-1:0]   r_full;
    logic [c_FR_W-1:0]   r_frame;
    logic [c_PH_W-1:0]   r_phase;
    logic [4:0]          r_rd;
    logic [4:0]          r_wr;

    logic [c_ROWS-1:0]   w_full;
    logic [199:0]        w_out_next;

    function automatic logic [199:0] expand_rows(input logic [c_ROWS-1:0] f);
        logic [199:0] m;
        m = '0;
        for (int r = 0; r < c_ROWS; r++) begin
            m[r*c_COLS +: c_COLS] = {c_COLS{f[r]}};
        end
        return m;
    endfunction

    function automatic logic [4:0] popcount(input logic [c_ROWS-1:0] f);
        logic [4:0] n;
        n = '0;
        for (int r = 0; r < c_ROWS; r++) begin
            n = n + 5'(f[r]);
        end
        return n;
    endfunction

    always_comb begin
        w_full = '0;
        for (int r = 0; r < c_ROWS; r++) begin
            w_full[r] = &r_snap[r*c_COLS +: c_COLS];
        end
    end

    // One compaction step: surviving row rd lands at wr, full rows are dropped.
    always_comb begin
        w_out_next = r_out;
        if (!r_full[r_rd]) begin
            w_out_next[int'(r_wr)*c_COLS +: c_COLS] = r_snap[int'(r_rd)*c_COLS +: c_COLS];
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state         <= S_IDLE;
            r_snap          <= '0;
            r_out           <= '0;
            r_full          <= '0;
            r_frame         <= '0;
            r_phase         <= '0;
            r_rd            <= '0;
            r_wr            <= '0;
            o_busy          <= 1'b0;
            o_flash         <= '0;
            o_matrix_out    <= '0;
            o_matrix_we     <= 1'b0;
            o_lines_cleared <= '0;
            o_done          <= 1'b0;
        end else begin
            o_matrix_we <= 1'b0;
            o_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_snap  <= i_matrix_in;
                        o_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_full          <= w_full;
                    o_lines_cleared <= popcount(w_full);
                    if (w_full == '0) begin
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_phase <= '0;
                        r_frame <= '0;
                        o_flash <= expand_rows(w_full);
                        r_state <= S_FLASH;
                    end
                end
                S_FLASH: begin
                    if (i_frame_tick) begin
                        if (r_frame == c_LAST_FRAME) begin
                            r_frame <= '0;
                            if (r_phase == c_LAST_PHASE) begin
                                o_flash <= '0;
                                r_out   <= '0;
                                r_rd    <= c_BOTTOM_ROW;
                                r_wr    <= c_BOTTOM_ROW;
                                r_state <= S_COMPACT;
                            end else begin
                                // Next phase is even (lit) exactly when the current one is odd.
                                r_phase <= r_phase + 1'b1;
                                o_flash <= r_phase[0] ? expand_rows(r_full) : '0;
                            end
                        end else begin
                            r_frame <= r_frame + 1'b1;
                        end
                    end
                end
                S_COMPACT: begin
                    r_out <= w_out_next;
                    if (!r_full[r_rd]) begin
                        r_wr <= r_wr - 1'b1;
                    end
                    if (r_rd == 5'd0) begin
                        o_matrix_out <= w_out_next;
                        o_matrix_we  <= 1'b1;
                        o_done       <= 1'b1;
                        r_state      <= S_WRITE;
                    end else begin
                        r_rd <= r_rd - 1'b1;
                    end
                end
                S_WRITE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
